// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: the in-flight scoreboard entry and the
// forwarding-select encoding used by the hazard logic.
package riscv_pipe_pkg;

  // Widest register address the entry can hold; narrower RA_W values are zero-extended.
  localparam int RA_W_MAX = 8;

  // Forward select 0 means "take the register file"; k>0 means "output of stage k".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                we;
    logic                load;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Priority match of one decode source register against the in-flight
// entries; the youngest (lowest stage number) producer wins.
module hazard_match
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  entry_t [DEPTH:1]      entries,
  input  logic [RA_W_MAX-1:0]   rs,
  input  logic                  use_rs,
  output logic [SEL_W-1:0]      sel,
  output logic                  sel_load
);

  // NOTE: every output gets a default before the loop, otherwise an
  // unmatched path would hold its old value and infer a latch.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    sel_load = 1'b0;
    // Scan oldest to youngest so the last hit (smallest k) is what remains.
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_rs && (rs != '0) && entries[k].valid && entries[k].we &&
          (entries[k].rd == rs)) begin
        sel      = SEL_W'(k);
        sel_load = entries[k].load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks destination registers of the
// instructions after decode, selects forwarding sources and load-use stalls.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int RA_W       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [RA_W-1:0]              dec_rs1,
  input  logic [RA_W-1:0]              dec_rs2,
  input  logic                         dec_use_rs1,
  input  logic                         dec_use_rs2,
  input  logic [RA_W-1:0]              dec_rd,
  input  logic                         dec_we,
  input  logic                         dec_is_load,
  input  logic                         redirect,
  output logic                         stall,
  output logic                         issue,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a_sel,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b_sel,
  output logic [DEPTH-1:0]             inflight,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  entry_t [DEPTH:1]    entry_q, entry_d;
  logic   [31:0]       stall_cnt_q, stall_cnt_d;
  logic   [31:0]       flush_cnt_q, flush_cnt_d;

  logic [RA_W_MAX-1:0] rs1_ext, rs2_ext, rd_ext;
  logic [SEL_W-1:0]    sel_a, sel_b;
  logic                load_a, load_b;
  logic                load_use;

  assign rs1_ext = RA_W_MAX'(dec_rs1);
  assign rs2_ext = RA_W_MAX'(dec_rs2);
  assign rd_ext  = RA_W_MAX'(dec_rd);

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .entries  (entry_q),
    .rs       (rs1_ext),
    .use_rs   (dec_valid & dec_use_rs1),
    .sel      (sel_a),
    .sel_load (load_a)
  );

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .entries  (entry_q),
    .rs       (rs2_ext),
    .use_rs   (dec_valid & dec_use_rs2),
    .sel      (sel_b),
    .sel_load (load_b)
  );

  // A matched load is usable only once it reaches LOAD_READY.
  always_comb begin
    load_use = 1'b0;
    if (load_a && (int'(sel_a) < LOAD_READY)) load_use = 1'b1;
    if (load_b && (int'(sel_b) < LOAD_READY)) load_use = 1'b1;
  end

  // Redirect and reset both override the stall and block issue.
  assign stall     = load_use & ~redirect & ~rst;
  assign issue     = dec_valid & ~load_use & ~redirect & ~rst;
  assign fwd_a_sel = rst ? SEL_W'(FWD_RF) : sel_a;
  assign fwd_b_sel = rst ? SEL_W'(FWD_RF) : sel_b;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      inflight[k-1] = entry_q[k].valid;
    end
  end

  always_comb begin
    entry_d = entry_q;
    entry_d[1] = ENTRY_BUBBLE;
    if (issue) begin
      entry_d[1].valid = 1'b1;
      entry_d[1].rd    = rd_ext;
      entry_d[1].we    = dec_we & (dec_rd != '0);
      entry_d[1].load  = dec_is_load;
    end
    for (int k = 2; k <= DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
    end
    if (redirect) begin
      for (int k = 1; k <= DEPTH; k++) begin
        entry_d[k].valid = 1'b0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    flush_cnt_d = flush_cnt_q;
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // NOTE: the entry array is small flop state whose valid bits gate every
  // match, so it is reset in full rather than left as an unreset memory.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a DEPTH=3/LOAD_READY=2 instance driven by a vector table
// plus hand sequences, and a DEPTH=5/LOAD_READY=4 instance for a long load-use.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_use_rs1, dec_use_rs2, dec_we, dec_is_load, redirect;

  logic        s3_stall, s3_issue;
  logic [1:0]  s3_fa, s3_fb;
  logic [2:0]  s3_infl;
  logic [31:0] s3_scnt, s3_fcnt;

  logic        s5_stall, s5_issue;
  logic [2:0]  s5_fa, s5_fb;
  logic [4:0]  s5_infl;
  logic [31:0] s5_scnt, s5_fcnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .LOAD_READY(2), .RA_W(5)) u_d3 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .redirect(redirect), .stall(s3_stall), .issue(s3_issue),
    .fwd_a_sel(s3_fa), .fwd_b_sel(s3_fb), .inflight(s3_infl),
    .stall_cnt(s3_scnt), .flush_cnt(s3_fcnt)
  );

  hazard_scoreboard #(.DEPTH(5), .LOAD_READY(4), .RA_W(5)) u_d5 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_we(dec_we),
    .dec_is_load(dec_is_load), .redirect(redirect), .stall(s5_stall), .issue(s5_issue),
    .fwd_a_sel(s5_fa), .fwd_b_sel(s5_fb), .inflight(s5_infl),
    .stall_cnt(s5_scnt), .flush_cnt(s5_fcnt)
  );

  typedef struct {
    logic       dv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, ld, redir;
    logic       e_stall, e_issue;
    logic [1:0] e_fa, e_fb;
    logic [2:0] e_infl;
    int         e_scnt, e_fcnt;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic redir);
    dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    dec_rd = rd; dec_we = we; dec_is_load = ld; redirect = redir;
  endtask

  initial begin
    //           dv rs1 rs2 u1 u2 rd  we ld rdr  stl iss fa fb infl  sc fc
    vecs[0]  = '{0, 0,  0,  0, 0, 0,  0, 0, 0,   0,  0,  0, 0, 3'b000, 0, 0};
    vecs[1]  = '{1, 1,  2,  1, 1, 5,  1, 0, 0,   0,  1,  0, 0, 3'b000, 0, 0};
    vecs[2]  = '{1, 5,  0,  1, 1, 8,  1, 0, 0,   0,  1,  1, 0, 3'b001, 0, 0};
    vecs[3]  = '{1, 5,  8,  1, 1, 6,  1, 1, 0,   0,  1,  2, 1, 3'b011, 0, 0};
    vecs[4]  = '{1, 0,  6,  1, 1, 9,  1, 0, 0,   1,  0,  0, 1, 3'b111, 0, 0};
    vecs[5]  = '{1, 0,  6,  1, 1, 9,  1, 0, 0,   0,  1,  0, 2, 3'b110, 1, 0};
    vecs[6]  = '{1, 0,  0,  0, 0, 7,  1, 0, 0,   0,  1,  0, 0, 3'b101, 1, 0};
    vecs[7]  = '{1, 0,  0,  0, 0, 10, 1, 0, 0,   0,  1,  0, 0, 3'b011, 1, 0};
    vecs[8]  = '{1, 0,  0,  0, 0, 7,  1, 0, 0,   0,  1,  0, 0, 3'b111, 1, 0};
    vecs[9]  = '{1, 7,  0,  1, 1, 0,  1, 0, 0,   0,  1,  1, 0, 3'b111, 1, 0};
    vecs[10] = '{1, 0,  7,  1, 1, 11, 0, 0, 0,   0,  1,  0, 2, 3'b111, 1, 0};
    vecs[11] = '{1, 0,  0,  0, 0, 12, 1, 1, 0,   0,  1,  0, 0, 3'b111, 1, 0};
    vecs[12] = '{1, 12, 0,  1, 0, 13, 1, 0, 1,   0,  0,  1, 0, 3'b111, 1, 0};
    vecs[13] = '{0, 0,  0,  0, 0, 0,  0, 0, 0,   0,  0,  0, 0, 3'b000, 1, 1};
    vecs[14] = '{1, 12, 0,  1, 0, 0,  0, 0, 0,   0,  1,  0, 0, 3'b000, 1, 1};

    rst = 1'b1;
    drive(1, 5, 6, 1, 1, 5, 1, 1, 0);
    #2;
    check("rst.stall", 32'(s3_stall), 32'd0);
    check("rst.issue", 32'(s3_issue), 32'd0);
    check("rst.fa", 32'(s3_fa), 32'd0);
    check("rst.infl", 32'(s3_infl), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].dv, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].we, vecs[i].ld, vecs[i].redir);
      #1;
      check($sformatf("v%0d.stall", i), 32'(s3_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d.issue", i), 32'(s3_issue), 32'(vecs[i].e_issue));
      check($sformatf("v%0d.fa", i), 32'(s3_fa), 32'(vecs[i].e_fa));
      check($sformatf("v%0d.fb", i), 32'(s3_fb), 32'(vecs[i].e_fb));
      check($sformatf("v%0d.infl", i), 32'(s3_infl), 32'(vecs[i].e_infl));
      check($sformatf("v%0d.scnt", i), s3_scnt, 32'(vecs[i].e_scnt));
      check($sformatf("v%0d.fcnt", i), s3_fcnt, 32'(vecs[i].e_fcnt));
      @(negedge clk);
    end

    // Mid-stream asynchronous reset with a load-use stall pending.
    drive(1, 0, 0, 0, 0, 20, 1, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 21, 1, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0, 0, 13, 1, 1, 0); @(negedge clk);
    drive(1, 13, 0, 1, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst.infl", 32'(s3_infl), 32'b111);
    check("pre_rst.stall", 32'(s3_stall), 32'd1);
    check("pre_rst.scnt", s3_scnt, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.infl", 32'(s3_infl), 32'd0);
    check("mid_rst.scnt", s3_scnt, 32'd0);
    check("mid_rst.fcnt", s3_fcnt, 32'd0);
    check("mid_rst.stall", 32'(s3_stall), 32'd0);
    check("mid_rst.issue", 32'(s3_issue), 32'd0);
    check("mid_rst.fa", 32'(s3_fa), 32'd0);
    check("mid_rst.d5infl", 32'(s5_infl), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Long load-use on the DEPTH=5, LOAD_READY=4 instance.
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    #1;
    check("d5.ld_issue", 32'(s5_issue), 32'd1);
    @(negedge clk);
    drive(1, 0, 6, 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("d5.stall%0d", c), 32'(s5_stall), 32'd1);
      check($sformatf("d5.noissue%0d", c), 32'(s5_issue), 32'd0);
      @(negedge clk);
    end
    #1;
    check("d5.stall_end", 32'(s5_stall), 32'd0);
    check("d5.fb", 32'(s5_fb), 32'd4);
    check("d5.issue", 32'(s5_issue), 32'd1);
    check("d5.scnt", s5_scnt, 32'd3);
    check("d5.infl", 32'(s5_infl), 32'b01000);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3: in-flight stages tracked after decode (1=EX ... DEPTH=WB); legal range 2..6.
REQ-002 SHALL have parameter LOAD_READY, default 2: first stage whose output holds load data; legal range 1..DEPTH.
REQ-003 SHALL have parameter RA_W, default 5: register address width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port dec_valid  input  1  decode stage holds a valid instruction.
REQ-007 SHALL have ports dec_rs1, dec_rs2  input  RA_W  decode source registers.
REQ-008 SHALL have ports dec_use_rs1, dec_use_rs2  input  1  source actually read.
REQ-009 SHALL have ports dec_rd  input  RA_W, dec_we  input  1, dec_is_load  input  1: decode destination info.
REQ-010 SHALL have port redirect  input  1  taken branch/jump resolved in WB (wb_pc_src).
REQ-011 SHALL have port stall  output  1  hold IF and DEC registers.
REQ-012 SHALL have port issue  output  1  decode instruction advances into EX this cycle.
REQ-013 SHALL have ports fwd_a_sel, fwd_b_sel  output  $clog2(DEPTH+1)  0=register file, k=output of stage k.
REQ-014 SHALL have port inflight  output  DEPTH  valid bit per tracked stage.
REQ-015 SHALL have ports stall_cnt, flush_cnt  output  32  performance counters.

Function
REQ-016 SHALL keep DEPTH entries {valid, rd, we, load}; every cycle entry[k] <= entry[k-1] for k=2..DEPTH.
REQ-017 SHALL load entry[1] with decode info when issue=1, else with a bubble (valid=0).
REQ-018 SHALL record we=0 when dec_rd==0; x0 SHALL never match or forward.
REQ-019 SHALL, per used source rs!=0, select the smallest k with entry[k].valid & we & rd==rs (youngest producer).
REQ-020 SHALL drive fwd_x_sel=k for a match, 0 for no match, unused source or rs==0.
REQ-021 SHALL assert stall combinationally when a matched producer has load=1 and k<LOAD_READY.
REQ-022 SHALL compute issue = dec_valid & ~stall & ~redirect.
REQ-023 SHALL, on redirect, invalidate all entries at the next edge, force stall=0 and issue=0 that cycle; redirect overrides stall.
REQ-024 SHALL add no latency to stall/fwd/issue (combinational from inputs and state); state updates one edge later.
REQ-025 SHALL increment stall_cnt on every cycle with stall=1 and flush_cnt on every cycle with redirect=1; both saturate at 0xFFFFFFFF.
REQ-026 SHALL ignore dec_* hazard checks when dec_valid=0 (stall=0, fwd sels 0).

Reset
REQ-027 SHALL on rst clear all entry valid bits, inflight=0, stall_cnt=0, flush_cnt=0 immediately, independent of clk.
REQ-028 SHALL, during reset, drive stall=0, issue=0, fwd_a_sel=fwd_b_sel=0; reset mid-operation discards all in-flight state.

Structure
REQ-029 SHALL take the entry struct typedef and the fwd-select encoding constants (FWD_RF=0) from the shared pipeline package riscv_pipe_pkg.
REQ-030 SHALL implement the per-source priority match as sub-module hazard_match, instantiated twice (rs1, rs2).
REQ-031 SHALL support any legal parameter combination without source edits.

Verification
REQ-032 SHALL cover: DEPTH=3; add x5 issued, next cycle dec_rs1=5 -> fwd_a_sel=1, stall=0, issue=1.
REQ-033 SHALL cover: lw x6 issued, next cycle dec_rs2=6, LOAD_READY=2 -> stall=1 one cycle, then fwd_b_sel=2, issue=1, stall_cnt=1.
REQ-034 SHALL cover: x7 written in stages 1 and 3, dec_rs1=7 -> fwd_a_sel=1 (youngest wins); dec_rd=0 writer -> dec_rs1=0 gives fwd_a_sel=0.
REQ-035 SHALL cover: load-use stall coinciding with redirect=1 -> stall=0, issue=0, inflight=000 next cycle, flush_cnt=1.
REQ-036 SHALL cover: rst asserted mid-stream with inflight=111 -> inflight=000 and counters 0 without waiting for clk.
REQ-037 SHALL cover: DEPTH=5, LOAD_READY=4 load-use -> stall held exactly 3 cycles, then fwd_sel=4.
